// File: rtl/adder_arbiter_pkg.sv
// ============================================================================
//  Module   : adder_arbiter_pkg
//  Brief    : Shared types and constants for the two-requester add/sub arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_arbiter_pkg;

    localparam int DATA_W = 8;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/adder_arbiter_if.sv
// ============================================================================
//  Module   : adder_arbiter_if
//  Brief    : Request/response bundle between the two clients and the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adder_arbiter_if
    import adder_arbiter_pkg::*;
#(
    parameter int W = DATA_W
) ();

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_add;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_add;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_v;
    logic [15:0]  op_cnt;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_add,
        input  req1_valid, req1_a, req1_b, req1_add,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_v, op_cnt
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_add,
        output req1_valid, req1_a, req1_b, req1_add,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_v, op_cnt
    );

endinterface

`default_nettype wire

// File: rtl/adder_arbiter_addsub.sv
// ============================================================================
//  Module   : addsub_unit
//  Brief    : Combinational W-bit generate/propagate add/sub with carry and
//             two's-complement overflow.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_unit
    import adder_arbiter_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  wire logic [W-1:0] i_a,
    input  wire logic [W-1:0] i_b,
    input  wire logic         i_add,
    output logic      [W-1:0] o_sum,
    output logic              o_cout,
    output logic              o_v
);

    logic [W-1:0] w_bx;
    logic [W-1:0] w_g;
    logic [W-1:0] w_p;
    logic [W:0]   w_c;

    // Subtract is a + ~b + 1: invert b and inject the +1 as carry-in.
    assign w_bx   = (i_add == OP_ADD) ? i_b : ~i_b;
    assign w_c[0] = (i_add == OP_SUB);
    assign w_g    = i_a & w_bx;
    assign w_p    = i_a ^ w_bx;

    generate
        for (genvar i = 0; i < W; i++) begin : g_carry
            assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
    endgenerate

    assign o_sum  = w_p ^ w_c[W-1:0];
    assign o_cout = w_c[W];
    assign o_v    = w_c[W] ^ w_c[W-1];

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
// ============================================================================
//  Module   : adder_arbiter
//  Brief    : Shares one add/sub unit between two requesters; IDLE/EXEC/RESP FSM
//             with registered, id-tagged responses. ADDER_ARB_RR_EN selects
//             round-robin arbitration, otherwise req0 has fixed priority.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  wire logic       clk,
    input  wire logic       rst,
    adder_arbiter_if.slave  bus
);

    state_t       r_state;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_add;
    logic         r_id;
    logic         r_rsp_valid;
    logic         r_rsp_id;
    logic [W-1:0] r_rsp_sum;
    logic         r_rsp_cout;
    logic         r_rsp_v;
    logic [15:0]  r_op_cnt;

    logic [W-1:0] w_sum;
    logic         w_cout;
    logic         w_v;
    logic         w_grant0;
    logic         w_grant1;
    logic         w_idle;

`ifdef ADDER_ARB_RR_EN
    logic r_last_grant;

    // On contention the requester that did not win last time is granted.
    assign w_grant0 = bus.req0_valid & (~bus.req1_valid | r_last_grant);
    assign w_grant1 = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
`else
    assign w_grant0 = bus.req0_valid;
    assign w_grant1 = bus.req1_valid & ~bus.req0_valid;
`endif

    assign w_idle         = (r_state == ST_IDLE) & ~rst;
    assign bus.req0_ready = w_idle & w_grant0;
    assign bus.req1_ready = w_idle & w_grant1;

    addsub_unit #(.W(W)) u_addsub (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_add  (r_add),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_v    (w_v)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_add       <= OP_ADD;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_v     <= 1'b0;
            r_op_cnt    <= 16'd0;
`ifdef ADDER_ARB_RR_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant0 | w_grant1) begin
                        r_a     <= w_grant1 ? bus.req1_a   : bus.req0_a;
                        r_b     <= w_grant1 ? bus.req1_b   : bus.req0_b;
                        r_add   <= w_grant1 ? bus.req1_add : bus.req0_add;
                        r_id    <= w_grant1;
                        r_state <= ST_EXEC;
`ifdef ADDER_ARB_RR_EN
                        r_last_grant <= w_grant1;
`endif
                    end
                end
                ST_EXEC: begin
                    r_rsp_sum   <= w_sum;
                    r_rsp_cout  <= w_cout;
                    r_rsp_v     <= w_v;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_op_cnt    <= r_op_cnt + 16'd1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_cout  = r_rsp_cout;
    assign bus.rsp_v     = r_rsp_v;
    assign bus.op_cnt    = r_op_cnt;

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// ============================================================================
//  Module   : tb_adder_arbiter
//  Brief    : Self-checking bench for adder_arbiter with a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_arbiter;
    import adder_arbiter_pkg::*;

    localparam int W = DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    adder_arbiter_if #(.W(W)) bus ();

    adder_arbiter #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Result as {v, cout, sum}, from unsigned and signed arithmetic.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic add);
        int unsigned ua, ub, full;
        int          sa, sb, sr;
        logic        vv;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        if (add) begin
            full = ua + ub;
            sr   = sa + sb;
        end else begin
            full = ua + (1 << W) - ub;
            sr   = sa - sb;
        end
        vv = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        return {vv, full[W], full[W-1:0]};
    endfunction

    // ---------------- behavioural model and per-cycle compare ----------------
    int              m_stage = 0;      // 0 free, 1 computing, 2 response held
    logic            m_id    = 1'b0;
    logic [W+1:0]    m_res   = '0;
    logic [15:0]     m_cnt   = 16'd0;
    logic            m_last  = 1'b1;

    always @(negedge clk) begin : p_compare
        logic g0, g1;
        if (rst) begin
            m_stage = 0;
            m_cnt   = 16'd0;
            m_last  = 1'b1;
            chk("rst_ready0", bus.req0_ready, 0);
            chk("rst_ready1", bus.req1_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_op_cnt", bus.op_cnt, 0);
        end else begin
            g0 = 1'b0;
            g1 = 1'b0;
            if (m_stage == 0) begin
                if (bus.req0_valid && bus.req1_valid) begin
`ifdef ADDER_ARB_RR_EN
                    g0 = m_last;
                    g1 = !m_last;
`else
                    g0 = 1'b1;
`endif
                end else begin
                    g0 = bus.req0_valid;
                    g1 = bus.req1_valid;
                end
            end
            chk("ready0", bus.req0_ready, g0);
            chk("ready1", bus.req1_ready, g1);
            chk("rsp_valid", bus.rsp_valid, m_stage == 2);
            chk("op_cnt", bus.op_cnt, m_cnt);
            if (m_stage == 2) begin
                chk("rsp_id", bus.rsp_id, m_id);
                chk("rsp_sum", bus.rsp_sum, m_res[W-1:0]);
                chk("rsp_cout", bus.rsp_cout, m_res[W]);
                chk("rsp_v", bus.rsp_v, m_res[W+1]);
            end
            case (m_stage)
                0: if (g0 || g1) begin
                    m_id    = g1;
                    m_res   = g1 ? ref_op(bus.req1_a, bus.req1_b, bus.req1_add)
                                 : ref_op(bus.req0_a, bus.req0_b, bus.req0_add);
                    m_last  = g1;
                    m_stage = 1;
                end
                1: m_stage = 2;
                default: if (bus.rsp_ready) begin
                    m_stage = 0;
                    m_cnt   = m_cnt + 16'd1;
                end
            endcase
        end
    end

    // ---------------- directed helpers ----------------
    task automatic apply_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic add, output logic [W+1:0] res, output logic rid,
                         output int lat);
        int n;
        res = '0;
        rid = 1'b0;
        lat = 0;
        @(posedge clk);
        #1;
        if (id) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_add = add; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_add = add; bus.req0_valid = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id ? bus.req1_ready : bus.req0_ready) && n < 50);
        if (!(id ? bus.req1_ready : bus.req0_ready)) begin
            chk("accept_timeout", 0, 1);
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 20);
        if (!bus.rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        res = {bus.rsp_v, bus.rsp_cout, bus.rsp_sum};
        rid = bus.rsp_id;
    endtask

    // ---------------- main sequence ----------------
    initial begin : p_main
        logic [W+1:0] res;
        logic         rid;
        int           lat;
        logic         ids[$];
        logic         acc0, acc1;

        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_add = 1'b1;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_add = 1'b1;
        bus.rsp_ready  = 1'b1;

        chk("model_7f_plus_1", ref_op(8'h7F, 8'h01, 1'b1), {1'b1, 1'b0, 8'h80});
        chk("model_3_minus_5", ref_op(8'h03, 8'h05, 1'b0), {1'b0, 1'b0, 8'hFE});
        chk("model_80_minus_1", ref_op(8'h80, 8'h01, 1'b0), {1'b1, 1'b1, 8'h7F});

        @(negedge clk);
        chk("reset_sum", bus.rsp_sum, 0);
        chk("reset_id", bus.rsp_id, 0);
        chk("reset_cout", bus.rsp_cout, 0);
        chk("reset_v", bus.rsp_v, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        do_op(1'b0, 8'h7F, 8'h01, 1'b1, res, rid, lat);
        chk("t1_sum", res[W-1:0], 8'h80);
        chk("t1_cout", res[W], 0);
        chk("t1_v", res[W+1], 1);
        chk("t1_id", rid, 0);
        chk("t1_latency", lat, 2);

        do_op(1'b1, 8'h03, 8'h05, 1'b0, res, rid, lat);
        chk("t2_sum", res[W-1:0], 8'hFE);
        chk("t2_cout", res[W], 0);
        chk("t2_v", res[W+1], 0);
        chk("t2_id", rid, 1);

        do_op(1'b1, 8'h80, 8'h01, 1'b0, res, rid, lat);
        chk("t3_sum", res[W-1:0], 8'h7F);
        chk("t3_cout", res[W], 1);
        chk("t3_v", res[W+1], 1);

        // Contention: both requesters valid continuously.
        apply_reset();
        @(posedge clk);
        #1;
        bus.req0_a = 8'h11; bus.req0_b = 8'h22; bus.req0_add = 1'b1; bus.req0_valid = 1'b1;
        bus.req1_a = 8'h33; bus.req1_b = 8'h44; bus.req1_add = 1'b0; bus.req1_valid = 1'b1;
        for (int i = 0; i < 60 && ids.size() < 4; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) ids.push_back(bus.rsp_id);
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("contention_count", ids.size(), 4);
        for (int i = 0; i < ids.size(); i++) begin
`ifdef ADDER_ARB_RR_EN
            chk("contention_grant", ids[i], i % 2);
`else
            chk("contention_grant", ids[i], 0);
`endif
        end

        // Response backpressure.
        apply_reset();
        bus.rsp_ready = 1'b0;
        do_op(1'b0, 8'h12, 8'h34, 1'b1, res, rid, lat);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_sum", bus.rsp_sum, 8'h46);
            chk("bp_ready0", bus.req0_ready, 0);
            chk("bp_ready1", bus.req1_ready, 0);
            chk("bp_op_cnt", bus.op_cnt, 0);
        end
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        repeat (2) @(negedge clk);
        chk("bp_op_cnt_after", bus.op_cnt, 1);
        chk("bp_valid_after", bus.rsp_valid, 0);

        // Reset while the op sits in EXEC: it must vanish without a response.
        apply_reset();
        @(posedge clk);
        #1;
        bus.req0_a = 8'hFF; bus.req0_b = 8'h01; bus.req0_add = 1'b1; bus.req0_valid = 1'b1;
        @(negedge clk);
        chk("mr_accept", bus.req0_ready, 1);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mr_no_rsp", bus.rsp_valid, 0);
            chk("mr_op_cnt", bus.op_cnt, 0);
        end
        @(posedge clk);
        #1 bus.req1_valid = 1'b1;
        @(negedge clk);
        chk("mr_idle_ready1", bus.req1_ready, 1);
        @(posedge clk);
        #1 bus.req1_valid = 1'b0;
        repeat (4) @(posedge clk);

        // Randomized traffic against the model.
        acc0 = 1'b0;
        acc1 = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            acc0 = bus.req0_valid & bus.req0_ready;
            acc1 = bus.req1_valid & bus.req1_ready;
            @(posedge clk);
            #1;
            if (acc0 || !bus.req0_valid) begin
                bus.req0_valid = 1'($urandom_range(0, 1));
                bus.req0_a     = W'($urandom);
                bus.req0_b     = W'($urandom);
                bus.req0_add   = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req0_valid = 1'b0;
            end
            if (acc1 || !bus.req1_valid) begin
                bus.req1_valid = 1'($urandom_range(0, 1));
                bus.req1_a     = W'($urandom);
                bus.req1_b     = W'($urandom);
                bus.req1_add   = 1'($urandom_range(0, 1));
            end else if ($urandom_range(0, 15) == 0) begin
                bus.req1_valid = 1'b0;
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

`default_nettype wire
